led_matrix_driver: RTL and testbench

LED_MATRIX_DRIVER -- requirements
Module: led_matrix_driver

---
 rtl/led_matrix_pkg.sv | 27 ++
 rtl/led_matrix_driver_row_timer.sv | 73 +++++++
 rtl/led_matrix_driver.sv | 109 ++++++++++
 tb/tb_led_matrix_driver.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and default timing for the 4x4 LED matrix scan driver.
package led_matrix_pkg;

    localparam int unsigned NUM_ROWS   = 4;
    localparam int unsigned NUM_COLS   = 4;
    localparam int unsigned LED_W      = NUM_ROWS * NUM_COLS;
    localparam int unsigned ROW_W      = 2;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned NUM_SLICES = 8;
    localparam int unsigned SLICE_W    = 3;

    localparam int unsigned DEFAULT_BLANK_CYCLES = 12;
    localparam int unsigned DEFAULT_SLICE_CYCLES = 150;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_SET = 2'd1,
        OP_CLR = 2'd2,
        OP_TOG = 2'd3
    } wr_op_e;

    typedef enum logic {
        ST_BLANK  = 1'b0,
        ST_ACTIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/led_matrix_driver_row_timer.sv
// Scan timing: blanking/active phase, brightness slice and row counters.
module led_row_timer
    import led_matrix_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
    parameter int unsigned SLICE_CYCLES = DEFAULT_SLICE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    output scan_state_e        phase_o,
    output logic [ROW_W-1:0]   row_o,
    output logic [SLICE_W-1:0] slice_idx_o,
    output logic               frame_tick_o
);

    localparam int unsigned MAX_CYC = (BLANK_CYCLES > SLICE_CYCLES) ? BLANK_CYCLES : SLICE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]   BLANK_LAST     = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SLICE_LAST     = CNT_W'(SLICE_CYCLES - 1);
    localparam logic [SLICE_W-1:0] SLICE_IDX_LAST = SLICE_W'(NUM_SLICES - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST       = ROW_W'(NUM_ROWS - 1);

    scan_state_e        state_q;
    logic [ROW_W-1:0]   row_q;
    logic [SLICE_W-1:0] slice_q;
    logic [CNT_W-1:0]   cyc_q;
    logic               frame_tick_q;

    // frame_tick_q marks the first blanking cycle of row 0, including right after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            row_q        <= '0;
            slice_q      <= '0;
            cyc_q        <= '0;
            frame_tick_q <= 1'b1;
        end else begin
            frame_tick_q <= 1'b0;
            case (state_q)
                ST_BLANK: begin
                    if (cyc_q == BLANK_LAST) begin
                        state_q <= ST_ACTIVE;
                        cyc_q   <= '0;
                    end else begin
                        cyc_q <= cyc_q + CNT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (cyc_q == SLICE_LAST) begin
                        cyc_q <= '0;
                        if (slice_q == SLICE_IDX_LAST) begin
                            state_q      <= ST_BLANK;
                            slice_q      <= '0;
                            row_q        <= row_q + ROW_W'(1);
                            frame_tick_q <= (row_q == ROW_LAST);
                        end else begin
                            slice_q <= slice_q + SLICE_W'(1);
                        end
                    end else begin
                        cyc_q <= cyc_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign phase_o      = state_q;
    assign row_o        = row_q;
    assign slice_idx_o  = slice_q;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: rtl/led_matrix_driver.sv
// 4x4 LED matrix driver: double-buffered pattern, row scan with PWM brightness and cursor overlay.
module led_matrix_driver
    import led_matrix_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
    parameter int unsigned SLICE_CYCLES = DEFAULT_SLICE_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_index,
    input  logic [1:0]          wr_op,
    input  logic                load_en,
    input  logic [LED_W-1:0]    load_data,
    input  logic                cursor_en,
    input  logic [IDX_W-1:0]    cursor_index,
    input  logic [SLICE_W-1:0]  brightness,
    output logic [NUM_ROWS-1:0] row_outputs,
    output logic [NUM_COLS-1:0] col_outputs,
    output logic [LED_W-1:0]    pattern,
    output logic                frame_start
);

    scan_state_e        phase;
    logic [ROW_W-1:0]   row_idx;
    logic [SLICE_W-1:0] slice_idx;
    logic               frame_tick;

    logic [LED_W-1:0]    working_q, working_d;
    logic [LED_W-1:0]    display_q;
    logic [SLICE_W-1:0]  bright_q;
    logic                cur_en_q;
    logic [IDX_W-1:0]    cur_idx_q;
    logic [NUM_ROWS-1:0] row_q, row_d;
    logic [NUM_COLS-1:0] col_q, col_d;
    logic                frame_start_q;
    logic [LED_W-1:0]    eff;

    led_row_timer #(
        .BLANK_CYCLES (BLANK_CYCLES),
        .SLICE_CYCLES (SLICE_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .phase_o      (phase),
        .row_o        (row_idx),
        .slice_idx_o  (slice_idx),
        .frame_tick_o (frame_tick)
    );

    // Working buffer update; a bulk load wins over a single-LED write
    always_comb begin
        working_d = working_q;
        if (load_en) begin
            working_d = load_data;
        end else if (wr_en) begin
            case (wr_op_e'(wr_op))
                OP_NOP: working_d = working_q;
                OP_SET: working_d[wr_index] = 1'b1;
                OP_CLR: working_d[wr_index] = 1'b0;
                OP_TOG: working_d[wr_index] = ~working_q[wr_index];
            endcase
        end
    end

    // Row/column drive from the display buffer and the frame's shadowed settings
    always_comb begin
        eff   = display_q ^ (cur_en_q ? (LED_W'(1) << cur_idx_q) : '0);
        row_d = '1;
        col_d = '0;
        if (phase == ST_ACTIVE) begin
            row_d[row_idx] = 1'b0;
            if (slice_idx <= bright_q) begin
                col_d = eff[{row_idx, 2'b00} +: NUM_COLS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            working_q     <= '0;
            display_q     <= '0;
            bright_q      <= '0;
            cur_en_q      <= 1'b0;
            cur_idx_q     <= '0;
            row_q         <= '1;
            col_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            working_q     <= working_d;
            row_q         <= row_d;
            col_q         <= col_d;
            frame_start_q <= frame_tick;
            // Latch takes the pre-edge working buffer, so a same-cycle write lands next frame
            if (frame_tick) begin
                display_q <= working_q;
                bright_q  <= brightness;
                cur_en_q  <= cursor_en;
                cur_idx_q <= cursor_index;
            end
        end
    end

    assign row_outputs = row_q;
    assign col_outputs = col_q;
    assign pattern     = working_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_driver.sv
// Scoreboard bench for led_matrix_driver against a frame-time arithmetic reference model.
module tb_led_matrix_driver;

    localparam int BLANK      = 12;
    localparam int SLICE      = 150;
    localparam int ROW_PERIOD = BLANK + 8 * SLICE;
    localparam int FRAME      = 4 * ROW_PERIOD;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_index;
    logic [1:0]  wr_op;
    logic        load_en;
    logic [15:0] load_data;
    logic        cursor_en;
    logic [3:0]  cursor_index;
    logic [2:0]  brightness;
    logic [3:0]  row_outputs;
    logic [3:0]  col_outputs;
    logic [15:0] pattern;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] m_work;

    led_matrix_driver dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_index     (wr_index),
        .wr_op        (wr_op),
        .load_en      (load_en),
        .load_data    (load_data),
        .cursor_en    (cursor_en),
        .cursor_index (cursor_index),
        .brightness   (brightness),
        .row_outputs  (row_outputs),
        .col_outputs  (col_outputs),
        .pattern      (pattern),
        .frame_start  (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs derived from cycles elapsed since the last frame start
    initial begin : monitor
        bit          c_rst, c_stb, m_rstd;
        logic [2:0]  c_br, m_br;
        bit          c_ce, m_ce;
        logic [3:0]  c_ci, m_ci;
        logic [15:0] cur_work, m_disp, eff;
        logic [3:0]  e_row, e_col;
        int          tcnt, r, p, s;
        m_rstd = 1; tcnt = 0; cur_work = '0; m_disp = '0;
        m_br = '0; m_ce = 0; m_ci = '0;
        forever begin
            @(posedge clk);
            c_rst = rst; c_stb = wr_en | load_en;
            c_br = brightness; c_ce = cursor_en; c_ci = cursor_index;
            if (c_rst) begin
                m_rstd = 1;
                cur_work = '0;
            end else begin
                tcnt = m_rstd ? 0 : (tcnt + 1) % FRAME;
                m_rstd = 0;
                if (tcnt == 0) begin
                    m_disp = cur_work;
                    m_br = c_br; m_ce = c_ce; m_ci = c_ci;
                end
            end
            @(negedge clk);
            if (!c_rst && c_stb) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: strobe with no expected entry at %0t", $time);
                end else begin
                    cur_work = exp_q.pop_front();
                end
            end
            e_row = 4'hF; e_col = 4'h0;
            if (!c_rst) begin
                r = tcnt / ROW_PERIOD;
                p = tcnt % ROW_PERIOD;
                if (p >= BLANK) begin
                    s = (p - BLANK) / SLICE;
                    e_row[r] = 1'b0;
                    eff = m_disp ^ (m_ce ? (16'h0001 << m_ci) : 16'h0000);
                    if (s <= int'(m_br)) e_col = eff[r*4 +: 4];
                end
            end
            chk("row_outputs", 16'(row_outputs), 16'(e_row));
            chk("col_outputs", 16'(col_outputs), 16'(e_col));
            chk("frame_start", 16'(frame_start), 16'(!c_rst && tcnt == 0));
            chk("pattern", pattern, cur_work);
            chk("one_row_low", 16'($countones(~row_outputs) <= 1), 16'd1);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        int  n = 0;
        bit  seen = 0;
        while (!seen && n < FRAME + 200) begin
            @(negedge clk);
            n++;
            if (frame_start) seen = 1;
        end
        chk("wait_frame_seen", 16'(seen), 16'd1);
    endtask

    task automatic do_load(input logic [15:0] d);
        @(negedge clk);
        load_en = 1'b1; load_data = d;
        m_work = d;
        exp_q.push_back(m_work);
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] op, input logic [3:0] idx);
        @(negedge clk);
        wr_en = 1'b1; wr_op = op; wr_index = idx;
        case (op)
            2'd1: m_work = m_work | (16'h0001 << idx);
            2'd2: m_work = m_work & ~(16'h0001 << idx);
            2'd3: m_work = m_work ^ (16'h0001 << idx);
            default: m_work = m_work;
        endcase
        exp_q.push_back(m_work);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1; wr_en = 1'b0; wr_index = '0; wr_op = '0;
        load_en = 1'b0; load_data = '0; cursor_en = 1'b0; cursor_index = '0;
        brightness = 3'd7; m_work = '0;
        wait_cycles(3);
        rst = 1'b0;

        // A5A5 at full brightness
        do_load(16'hA5A5);
        wait_frame();
        wait_cycles(BLANK + 5);
        chk("a5_row0_row", 16'(row_outputs), 16'h000E);
        chk("a5_row0_col", 16'(col_outputs), 16'h0005);
        wait_cycles(8 * SLICE - 6);
        chk("a5_row0_last", 16'(col_outputs), 16'h0005);
        wait_cycles(BLANK + 6);
        chk("a5_row1_row", 16'(row_outputs), 16'h000D);
        chk("a5_row1_col", 16'(col_outputs), 16'h000A);

        // Minimum brightness: only slice 0 lit
        brightness = 3'd0;
        do_load(16'hFFFF);
        wait_frame();
        wait_cycles(BLANK);
        chk("b0_first", 16'(col_outputs), 16'h000F);
        wait_cycles(SLICE - 1);
        chk("b0_slice0_end", 16'(col_outputs), 16'h000F);
        wait_cycles(1);
        chk("b0_slice1", 16'(col_outputs), 16'h0000);
        wait_cycles(7 * SLICE - 1);
        chk("b0_row_end", 16'(col_outputs), 16'h0000);

        // Single-LED ops
        brightness = 3'd7;
        do_load(16'h0000);
        do_write(2'd3, 4'd5);
        do_write(2'd3, 4'd5);
        do_write(2'd1, 4'd15);
        do_write(2'd2, 4'd0);
        chk("ops_pattern", pattern, 16'h8000);
        wait_frame();
        wait_cycles(3 * ROW_PERIOD + BLANK);
        chk("ops_row3_col", 16'(col_outputs), 16'h0008);

        // Load beats write
        @(negedge clk);
        load_en = 1'b1; load_data = 16'h0000;
        wr_en = 1'b1; wr_op = 2'd1; wr_index = 4'd3;
        m_work = 16'h0000;
        exp_q.push_back(m_work);
        @(negedge clk);
        load_en = 1'b0; wr_en = 1'b0;
        chk("load_beats_write", pattern, 16'h0000);

        // Cursor overlay inverts LED 6
        cursor_en = 1'b1; cursor_index = 4'd6;
        do_load(16'h0040);
        wait_frame();
        wait_cycles(BLANK + 5);
        chk("cur_on_row0", 16'(col_outputs), 16'h0000);
        wait_cycles(ROW_PERIOD);
        chk("cur_on_row1", 16'(col_outputs), 16'h0000);
        do_load(16'h0000);
        wait_frame();
        wait_cycles(ROW_PERIOD + BLANK + 5);
        chk("cur_off_row1", 16'(col_outputs), 16'h0004);

        // Randomized traffic with occasional setting changes
        for (int i = 0; i < 5000; i++) begin
            case ($urandom_range(0, 5))
                0:       do_load(16'($urandom()));
                1, 2:    do_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
                default: wait_cycles($urandom_range(1, 4));
            endcase
            if ($urandom_range(0, 199) == 0) begin
                brightness   = 3'($urandom_range(0, 7));
                cursor_en    = 1'($urandom_range(0, 1));
                cursor_index = 4'($urandom_range(0, 15));
            end
        end

        // Reset mid-ACTIVE of row 2
        wait_frame();
        wait_cycles(2 * ROW_PERIOD + BLANK + 300);
        chk("pre_rst_row2", 16'(row_outputs), 16'h000B);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_row", 16'(row_outputs), 16'h000F);
        chk("rst_col", 16'(col_outputs), 16'h0000);
        chk("rst_pattern", pattern, 16'h0000);
        rst = 1'b0;
        m_work = '0;
        @(negedge clk);
        chk("post_rst_fs", 16'(frame_start), 16'h0001);
        wait_cycles(BLANK);
        chk("post_rst_row0", 16'(row_outputs), 16'h000E);
        wait_cycles(20);
        chk("sb_empty", 16'(exp_q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
